// File: rtl/uart_loopback_pkg.sv
// Shared types for the UART loopback FIFO block: transmit FSM states,
// the byte-transform modes and the ASCII constants used by the upper-case mode.
package uart_loopback_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_REQ   = 2'd1,
    TX_DRAIN = 2'd2
  } txState_t;

  typedef enum logic [1:0] {
    MODE_ECHO    = 2'b00,
    MODE_UPPER   = 2'b01,
    MODE_INVERT  = 2'b10,
    MODE_DISCARD = 2'b11
  } mode_t;

  localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pointers wrap naturally.
// A push against a full FIFO is accepted only when a pop happens in the
// same cycle. Read data is the head entry; there is no empty bypass.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_pushData,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_popData,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_doPop;
  logic w_doPush;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_level   = r_level;
  assign o_popData = r_mem[r_rdPtr];

  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Advance pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/uart_loopback_fifo.sv
// UART loopback: captures received bytes, transforms them by mode, queues
// them in a FIFO and hands them back to the UART core through a
// tx_en/tx_busy handshake with a timeout.
// Optional feature macro: LOOPBACK_STATS_EN adds rx_count/drop_count.
module uart_loopback_fifo
  import uart_loopback_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_busy,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   tx_busy,
  input  logic [1:0]             mode,
  input  logic                   clr_flags,
  output logic                   tx_en,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   tx_timeout
`ifdef LOOPBACK_STATS_EN
  ,
  output logic [15:0]            rx_count,
  output logic [15:0]            drop_count
`endif
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic              r_rxBusyQ;
  logic              w_rxDone;
  logic [DATA_W-1:0] w_captured;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [DATA_W-1:0] w_fifoData;

  txState_t          r_state;
  txState_t          w_stateNext;
  logic              r_txEn;
  logic              w_txEnNext;
  logic [DATA_W-1:0] r_txData;
  logic [DATA_W-1:0] w_txDataNext;
  logic [CNT_W-1:0]  r_ackCnt;
  logic [CNT_W-1:0]  w_ackCntNext;
  logic              w_timeoutHit;
  logic              r_overflow;
  logic              r_txTimeout;

  assign w_rxDone = r_rxBusyQ && !rx_busy;
  assign w_push   = w_rxDone && (mode_t'(mode) != MODE_DISCARD);
  assign w_drop   = w_push && w_full && !w_pop;

  // Delay rx_busy by one cycle so its falling edge marks a finished byte.
  always_ff @(posedge clk) begin
    if (reset) r_rxBusyQ <= 1'b0;
    else       r_rxBusyQ <= rx_busy;
  end

  // Transform the received byte according to the mode at capture time.
  always_comb begin
    w_captured = rx_data;
    case (mode_t'(mode))
      MODE_UPPER: begin
        if (rx_data >= DATA_W'(ASCII_LOWER_A) && rx_data <= DATA_W'(ASCII_LOWER_Z))
          w_captured = rx_data - DATA_W'(ASCII_CASE_DELTA);
      end
      MODE_INVERT: w_captured = ~rx_data;
      default:     w_captured = rx_data;
    endcase
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pushData (w_captured),
    .i_pop      (w_pop),
    .o_popData  (w_fifoData),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (fifo_level)
  );

  // Transmit FSM next state: pop in IDLE, wait for tx_busy in REQ, wait for it to clear in DRAIN.
  always_comb begin
    w_stateNext  = r_state;
    w_txEnNext   = r_txEn;
    w_txDataNext = r_txData;
    w_ackCntNext = r_ackCnt;
    w_pop        = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop        = 1'b1;
          w_txDataNext = w_fifoData;
          w_txEnNext   = 1'b1;
          w_ackCntNext = '0;
          w_stateNext  = TX_REQ;
        end
      end
      TX_REQ: begin
        if (tx_busy) begin
          w_txEnNext  = 1'b0;
          w_stateNext = TX_DRAIN;
        end else if (r_ackCnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_txEnNext   = 1'b0;
          w_timeoutHit = 1'b1;
          w_stateNext  = TX_IDLE;
        end else begin
          w_ackCntNext = r_ackCnt + CNT_W'(1);
        end
      end
      TX_DRAIN: begin
        if (!tx_busy) w_stateNext = TX_IDLE;
      end
      default: begin
        w_txEnNext  = 1'b0;
        w_stateNext = TX_IDLE;
      end
    endcase
  end

  // Transmit FSM state and its registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= TX_IDLE;
      r_txEn   <= 1'b0;
      r_txData <= '0;
      r_ackCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_txEn   <= w_txEnNext;
      r_txData <= w_txDataNext;
      r_ackCnt <= w_ackCntNext;
    end
  end

  // Sticky error flags; a set event in the same cycle beats clr_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_txTimeout <= 1'b0;
    end else begin
      if (w_drop)         r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
      if (w_timeoutHit)   r_txTimeout <= 1'b1;
      else if (clr_flags) r_txTimeout <= 1'b0;
    end
  end

  assign tx_en      = r_txEn;
  assign tx_data    = r_txData;
  assign overflow   = r_overflow;
  assign tx_timeout = r_txTimeout;

`ifdef LOOPBACK_STATS_EN
  logic [15:0] r_rxCount;
  logic [15:0] r_dropCount;

  // Saturating counters of completed receptions and dropped bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxCount   <= '0;
      r_dropCount <= '0;
    end else begin
      if (w_rxDone && r_rxCount != 16'hFFFF)   r_rxCount   <= r_rxCount + 16'd1;
      if (w_drop && r_dropCount != 16'hFFFF)   r_dropCount <= r_dropCount + 16'd1;
    end
  end

  assign rx_count   = r_rxCount;
  assign drop_count = r_dropCount;
`endif

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed testbench for uart_loopback_fifo (default parameters).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_uart_loopback_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       clr_flags = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       tx_timeout;
`ifdef LOOPBACK_STATS_EN
  logic [15:0] rx_count;
  logic [15:0] drop_count;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  uart_loopback_fifo #(
    .DATA_W      (8),
    .DEPTH       (16),
    .ACK_TIMEOUT (255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_busy    (rx_busy),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .mode       (mode),
    .clr_flags  (clr_flags),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .tx_timeout (tx_timeout)
`ifdef LOOPBACK_STATS_EN
    ,
    .rx_count   (rx_count),
    .drop_count (drop_count)
`endif
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one received byte; returns inside the rx_done cycle.
  task automatic applyStimulus(input logic [7:0] data);
    rx_busy = 1'b1;
    rx_data = data;
    tick();
    rx_busy = 1'b0;
  endtask

  // Acknowledge a pending tx_en; returns in the cycle the FSM is back in IDLE.
  task automatic ackTx(input string tag);
    tx_busy = 1'b1;
    tick();
    checkOutput({tag, "_ackdrop"}, {31'd0, tx_en}, 32'd0);
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic receiveAndCheck(input string tag, input logic [7:0] data, input logic [7:0] expected);
    applyStimulus(data);
    tick(2);
    checkOutput({tag, "_en"}, {31'd0, tx_en}, 32'd1);
    checkOutput({tag, "_data"}, {24'd0, tx_data}, {24'd0, expected});
    ackTx(tag);
  endtask

  initial begin
    // Reset state.
    tick(3);
    checkOutput("rst_txen", {31'd0, tx_en}, 32'd0);
    checkOutput("rst_txdata", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_level", {27'd0, fifo_level}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_tmo", {31'd0, tx_timeout}, 32'd0);
    reset = 1'b0;
    tick();

    // Echo with exact latency: rx_done at N, entry at N+1, tx_en at N+2.
    mode = 2'b00;
    applyStimulus(8'h41);
    checkOutput("echo_n_en", {31'd0, tx_en}, 32'd0);
    tick();
    checkOutput("echo_n1_level", {27'd0, fifo_level}, 32'd1);
    checkOutput("echo_n1_en", {31'd0, tx_en}, 32'd0);
    tick();
    checkOutput("echo_n2_en", {31'd0, tx_en}, 32'd1);
    checkOutput("echo_n2_data", {24'd0, tx_data}, 32'h41);
    checkOutput("echo_n2_level", {27'd0, fifo_level}, 32'd0);
    ackTx("echo");

    // Upper-case mode including range edges.
    mode = 2'b01;
    receiveAndCheck("up_61", 8'h61, 8'h41);
    receiveAndCheck("up_7a", 8'h7A, 8'h5A);
    receiveAndCheck("up_5b", 8'h5B, 8'h5B);
    receiveAndCheck("up_60", 8'h60, 8'h60);
    receiveAndCheck("up_7b", 8'h7B, 8'h7B);

    // Invert mode.
    mode = 2'b10;
    receiveAndCheck("inv_0f", 8'h0F, 8'hF0);

    // Discard mode: nothing queued, nothing sent.
    mode = 2'b11;
    applyStimulus(8'h55);
    tick(2);
    checkOutput("disc_en", {31'd0, tx_en}, 32'd0);
    checkOutput("disc_level", {27'd0, fifo_level}, 32'd0);
    checkOutput("disc_ovf", {31'd0, overflow}, 32'd0);

    // Overflow: hold tx_busy and receive 17 bytes 0x10..0x20.
    mode = 2'b00;
    tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'h10 + 8'(i));
      tick();
    end
    checkOutput("ovf_level", {27'd0, fifo_level}, 32'd16);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_txen", {31'd0, tx_en}, 32'd0);
`ifdef LOOPBACK_STATS_EN
    checkOutput("ovf_dropcnt", {16'd0, drop_count}, 32'd1);
`endif
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checkOutput("ovf_clr", {31'd0, overflow}, 32'd0);
    checkOutput("ovf_clr_level", {27'd0, fifo_level}, 32'd16);

    // Full FIFO: rx_done coincides with an IDLE pop -> no drop.
    applyStimulus(8'hAA);
    tx_busy = 1'b0;
    tick();
    checkOutput("full_pp_level", {27'd0, fifo_level}, 32'd16);
    checkOutput("full_pp_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("full_pp_en", {31'd0, tx_en}, 32'd1);
    checkOutput("full_pp_data", {24'd0, tx_data}, 32'h10);

    // Drain in order: 0x11..0x1F then 0xAA; dropped 0x20 never appears.
    for (int i = 1; i < 16; i++) begin
      ackTx("drain");
      tick();
      checkOutput("drain_data", {24'd0, tx_data}, 32'h10 + 32'(i));
    end
    ackTx("drain");
    tick();
    checkOutput("drain_last", {24'd0, tx_data}, 32'hAA);
    ackTx("drain");
    tick();
    checkOutput("drain_empty_en", {31'd0, tx_en}, 32'd0);
    checkOutput("drain_empty_level", {27'd0, fifo_level}, 32'd0);

    // Handshake timeout: tx_busy never rises.
    applyStimulus(8'h33);
    tick(2);
    checkOutput("tmo_start_en", {31'd0, tx_en}, 32'd1);
    tick(254);
    checkOutput("tmo_254_en", {31'd0, tx_en}, 32'd1);
    checkOutput("tmo_254_flag", {31'd0, tx_timeout}, 32'd0);
    clr_flags = 1'b1;
    tick();
    checkOutput("tmo_255_en", {31'd0, tx_en}, 32'd0);
    checkOutput("tmo_set_wins", {31'd0, tx_timeout}, 32'd1);
    checkOutput("tmo_level", {27'd0, fifo_level}, 32'd0);
    tick();
    clr_flags = 1'b0;
    checkOutput("tmo_clr", {31'd0, tx_timeout}, 32'd0);
    receiveAndCheck("tmo_idle", 8'h7E, 8'h7E);

    // Reset during REQ with three bytes still queued.
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'hC0 + 8'(i));
      tick();
    end
    tx_busy = 1'b0;
    tick();
    checkOutput("midrst_pre_en", {31'd0, tx_en}, 32'd1);
    checkOutput("midrst_pre_level", {27'd0, fifo_level}, 32'd3);
    reset = 1'b1;
    tick();
    checkOutput("midrst_en", {31'd0, tx_en}, 32'd0);
    checkOutput("midrst_level", {27'd0, fifo_level}, 32'd0);
    checkOutput("midrst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("midrst_tmo", {31'd0, tx_timeout}, 32'd0);
    checkOutput("midrst_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    tick(3);
    checkOutput("midrst_after_en", {31'd0, tx_en}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_loopback_fifo.md
UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: byte width on the UART core interface.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries, power of 2, >=2.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles to wait for tx_busy to rise after tx_en.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port rx_busy, input, 1: UART core receive-in-progress flag.
REQ-007 SHALL have port rx_data, input, DATA_W: received byte, valid in the cycle rx_busy falls.
REQ-008 SHALL have port tx_busy, input, 1: UART core transmit-in-progress flag.
REQ-009 SHALL have port mode, input, 2: 00 echo, 01 lower-to-upper ASCII, 10 bitwise invert, 11 discard.
REQ-010 SHALL have port clr_flags, input, 1: clears the sticky overflow and tx_timeout flags.
REQ-011 SHALL have port tx_en, output, 1: transmit request to the UART core.
REQ-012 SHALL have port tx_data, output, DATA_W: byte to transmit, stable while tx_en=1.
REQ-013 SHALL have port fifo_level, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-014 SHALL have port overflow, output, 1: sticky; set when a byte is dropped because the FIFO is full.
REQ-015 SHALL have port tx_timeout, output, 1: sticky; set when a transmit handshake times out.

Function
REQ-016 SHALL register rx_busy as rx_busy_q; byte complete when rx_busy_q=1 and rx_busy=0 (rx_done).
REQ-017 SHALL apply mode at capture and push the result into the FIFO on the edge ending the rx_done cycle.
REQ-018 In mode 01, bytes 0x61..0x7A SHALL have 0x20 subtracted; all other bytes pass unchanged.
REQ-019 In mode 11, bytes SHALL NOT be pushed and SHALL NOT set overflow.
REQ-020 When rx_done occurs with the FIFO full and no pop in the same cycle, the byte SHALL be dropped and overflow set.
REQ-021 Simultaneous push and pop SHALL both succeed at any level, including full; fifo_level is unchanged.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; there is no empty-to-output bypass.
REQ-023 TX FSM states SHALL be IDLE, REQ and DRAIN.
REQ-024 IDLE transition SHALL be taken when FIFO is non-empty and tx_busy=0: pop, load tx_data, tx_en<=1, go to REQ.
REQ-025 In REQ, when tx_busy=1, tx_en SHALL go to 0 and the FSM SHALL go to DRAIN.
REQ-026 In REQ, after ACK_TIMEOUT cycles without tx_busy, the FSM SHALL set tx_en<=0, set tx_timeout, go to IDLE, and lose the byte.
REQ-027 In DRAIN, when tx_busy=0, the FSM SHALL go to IDLE.
REQ-028 Latency SHALL be: rx_done in cycle N -> FIFO entry at N+1 -> tx_en high at N+2, when the FSM is idle.
REQ-029 If clr_flags and a set event coincide, the set SHALL win.
REQ-030 A mode change SHALL affect only bytes captured after it; queued bytes are unaffected.

Reset
REQ-031 On reset, the FIFO SHALL be emptied and the FSM placed in IDLE.
REQ-032 On reset, tx_en, tx_data, overflow, tx_timeout, fifo_level and rx_busy_q SHALL be 0.
REQ-033 Reset asserted mid-transmit SHALL drop tx_en on the next edge and discard queued bytes.

Configuration
REQ-034 With LOOPBACK_STATS_EN defined, ports rx_count[15:0] and drop_count[15:0] SHALL exist, reset to 0 and saturate at 0xFFFF.
REQ-035 rx_count SHALL increment on every rx_done; drop_count SHALL increment on every overflow drop.
REQ-036 Without LOOPBACK_STATS_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-037 Package uart_loopback_pkg SHALL hold the tx FSM state enum (logic [1:0]) and the mode enum with its four values.
REQ-038 The FIFO SHALL be sub-module sync_fifo (params DATA_W, DEPTH; push, pop, full, empty, level).

Verification
REQ-039 Mode 00, rx_data 0x41 then rx_busy falls -> tx_en at N+2 with tx_data=0x41; echo is byte-exact.
REQ-040 Mode 01, bytes 0x61, 0x7A, 0x5B -> transmitted 0x41, 0x5A, 0x5B; mode 10, 0x0F -> 0xF0.
REQ-041 Hold tx_busy=1 and receive 17 bytes with DEPTH=16 -> fifo_level=16, overflow=1, 17th byte absent; STATS build gives drop_count=1.
REQ-042 tx_busy never rises after tx_en -> after 255 cycles tx_en=0, tx_timeout=1, FSM back in IDLE; clr_flags clears it.
REQ-043 Full FIFO with rx_done coinciding with an IDLE pop -> no drop, level stays 16.
REQ-044 Reset during REQ with 3 bytes queued -> next edge tx_en=0, fifo_level=0, all flags 0.
